// File: rtl/csa_pkg.sv
// Shared widths and encodings for the control-word key scheduling slice.
package csa_pkg;

    localparam int unsigned CK_W  = 64;
    localparam int unsigned KK_W  = 448;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_STORE = 2'd3
    } ks_state_e;

    typedef enum logic {
        SLOT_EVEN = 1'b0,
        SLOT_ODD  = 1'b1
    } slot_e;

endpackage

// File: rtl/ks_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant, the slot not served last wins ties.
module ks_rr_arb (
    input  logic       req_even,
    input  logic       req_odd,
    input  logic       last_odd,
    output logic [1:0] grant      // bit 0 = even, bit 1 = odd
);

    // Grant the sole requester, or on contention the one served less recently
    always_comb begin
        grant = '0;
        if (req_even && req_odd) begin
            grant = last_odd ? 2'b01 : 2'b10;
        end else if (req_even) begin
            grant = 2'b01;
        end else if (req_odd) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/key_sched_ctrl.sv
// Sequences even/odd control-word loads through an external key_schedule unit
// and keeps one expanded key per slot for the consumer.
module key_sched_ctrl
    import csa_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_even,
    input  logic            req_odd,
    input  logic [CK_W-1:0] ck_even,
    input  logic [CK_W-1:0] ck_odd,
    output logic            ack_even,
    output logic            ack_odd,
    output logic            ks_start,
    output logic [CK_W-1:0] ks_ck,
    input  logic            ks_busy,
    input  logic            ks_done,
    input  logic [KK_W-1:0] ks_kk,
    input  logic            sel_odd,
    output logic [KK_W-1:0] o_kk,
    output logic            o_kk_valid,
    output logic            kk_even_valid,
    output logic            kk_odd_valid,
    output logic            busy,
    output logic            err
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);

    ks_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CK_W-1:0]  ks_ck_q, ks_ck_d;
    slot_e            slot_q, slot_d;
    logic             last_odd_q, last_odd_d;
    logic [KK_W-1:0]  kk_even_q, kk_even_d;
    logic [KK_W-1:0]  kk_odd_q, kk_odd_d;
    logic             val_even_q, val_even_d;
    logic             val_odd_q, val_odd_d;
    logic [1:0]       grant;

    // ks_busy is informational only; it never steers the sequencer
    logic ks_busy_unused;
    assign ks_busy_unused = ks_busy;

    ks_rr_arb u_arb (
        .req_even (req_even),
        .req_odd  (req_odd),
        .last_odd (last_odd_q),
        .grant    (grant)
    );

    // State register and slot storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ks_ck_q    <= '0;
            slot_q     <= SLOT_EVEN;
            last_odd_q <= 1'b1;
            kk_even_q  <= '0;
            kk_odd_q   <= '0;
            val_even_q <= 1'b0;
            val_odd_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ks_ck_q    <= ks_ck_d;
            slot_q     <= slot_d;
            last_odd_q <= last_odd_d;
            kk_even_q  <= kk_even_d;
            kk_odd_q   <= kk_odd_d;
            val_even_q <= val_even_d;
            val_odd_q  <= val_odd_d;
        end
    end

    // Next-state, datapath updates and strobes
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ks_ck_d    = ks_ck_q;
        slot_d     = slot_q;
        last_odd_d = last_odd_q;
        kk_even_d  = kk_even_q;
        kk_odd_d   = kk_odd_q;
        val_even_d = val_even_q;
        val_odd_d  = val_odd_q;
        ks_start   = 1'b0;
        ack_even   = 1'b0;
        ack_odd    = 1'b0;
        err        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (grant[1]) begin
                    slot_d     = SLOT_ODD;
                    last_odd_d = 1'b1;
                    ks_ck_d    = ck_odd;
                    val_odd_d  = 1'b0;
                    state_d    = ST_START;
                end else if (grant[0]) begin
                    slot_d     = SLOT_EVEN;
                    last_odd_d = 1'b0;
                    ks_ck_d    = ck_even;
                    val_even_d = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                ks_start = 1'b1;
                cnt_d    = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion outranks the timeout in the cycle the count expires
                if (ks_done) begin
                    state_d = ST_STORE;
                end else if (cnt_q == TMO) begin
                    err      = 1'b1;
                    ack_even = (slot_q == SLOT_EVEN);
                    ack_odd  = (slot_q == SLOT_ODD);
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STORE: begin
                ack_even = (slot_q == SLOT_EVEN);
                ack_odd  = (slot_q == SLOT_ODD);
                if (slot_q == SLOT_ODD) begin
                    kk_odd_d  = ks_kk;
                    val_odd_d = 1'b1;
                end else begin
                    kk_even_d  = ks_kk;
                    val_even_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ks_ck         = ks_ck_q;
    assign busy          = (state_q != ST_IDLE);
    assign kk_even_valid = val_even_q;
    assign kk_odd_valid  = val_odd_q;
    assign o_kk          = sel_odd ? kk_odd_q : kk_even_q;
    assign o_kk_valid    = sel_odd ? val_odd_q : val_even_q;

endmodule

// File: doc/key_sched_ctrl.md
KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYC, 255, max WAIT cycles before abort (1..65535).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req_even / req_odd  input  1 each  load request for even / odd control-word slot.
REQ-005 ck_even / ck_odd  input  64 each  control word; held stable while matching req is high.
REQ-006 ack_even / ack_odd  output  1 each  one-cycle completion pulse for the served requester.
REQ-007 ks_start  output  1  one-cycle start to the key_schedule unit.
REQ-008 ks_ck  output  64  control word to the key_schedule unit.
REQ-009 ks_busy / ks_done  input  1 each  key_schedule status; ks_done is a pulse.
REQ-010 ks_kk  input  448  expanded key from the key_schedule unit.
REQ-011 sel_odd  input  1  consumer slot select; 0 = even, 1 = odd.
REQ-012 o_kk  output  448  stored key of the selected slot.
REQ-013 o_kk_valid  output  1  valid flag of the selected slot.
REQ-014 kk_even_valid / kk_odd_valid  output  1 each  per-slot valid flags.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 err  output  1  one-cycle pulse on timeout abort.

Function
REQ-017 FSM states: IDLE, START, WAIT, STORE; one state per cycle except WAIT.
REQ-018 IDLE: any req high -> grant one, latch its ck into ks_ck register, latch slot id, clear that slot's valid, go to START.
REQ-019 Both reqs high in IDLE -> round-robin: grant the slot not served last; last-served updates on every grant.
REQ-020 START: ks_start=1 for exactly one cycle -> WAIT; ks_ck stays stable from START until return to IDLE.
REQ-021 WAIT: wait counter starts at 0 and increments each WAIT cycle; ks_done=1 -> STORE.
REQ-022 WAIT: counter reaches TIMEOUT_CYC without ks_done -> err=1 and granted ack=1 in the same cycle, slot stays invalid, -> IDLE.
REQ-023 STORE: granted ack=1 for one cycle; ks_kk written into granted slot register and its valid set at the edge ending STORE; -> IDLE.
REQ-024 Latency: req sampled in IDLE at cycle N -> ks_start at N+1; ks_done at D -> ack at D+1, valid visible at D+2.
REQ-025 ks_done outside WAIT is ignored; ks_busy is status only and does not affect transitions.
REQ-026 Requests arriving outside IDLE are not lost: held reqs are arbitrated on the next IDLE cycle.
REQ-027 The non-granted slot's key and valid flag are untouched during a reload of the other slot.
REQ-028 o_kk / o_kk_valid: combinational mux of slot registers on sel_odd.

Reset
REQ-029 rst low asynchronously forces: state IDLE, slot registers and ks_ck to 0, all valids 0, ks_start/acks/err/busy 0, last-served = odd (even wins first).
REQ-030 Reset mid-operation abandons the load; no ack is issued for it.

Structure
REQ-031 Shared package csa_pkg holds CK_W=64, KK_W=448 and the FSM state encoding.
REQ-032 One sub-module, ks_rr_arb: two-way round-robin arbiter (req pair, last-served -> one-hot grant).
REQ-033 key_schedule is instantiated outside this block, at the level above, and connected via the ks_* ports.

Verification
REQ-034 Reset, req_even with ck_even=64'haf361916fd4b4b77 -> ks_start once, ks_ck equal to that value, ack_even after ks_done, kk_even_valid=1, o_kk (sel_odd=0) equals reference kk.
REQ-035 req_even and req_odd asserted same cycle after reset -> even served first, odd immediately after; one ack each, in that order.
REQ-036 Both reqs held continuously -> grants alternate even/odd/even; no slot is served twice in a row.
REQ-037 Stub never pulses ks_done, TIMEOUT_CYC=16 -> err and ack pulse together after 16 WAIT cycles; slot valid stays 0.
REQ-038 Odd valid, then reload odd while sel_odd=0 -> even key unchanged; kk_odd_valid drops at grant and rises after STORE.
REQ-039 rst low during WAIT -> all outputs 0 immediately; no ack; next request after reset completes normally.
